vtp_xlate_pipe: RTL
===================

# vtp_xlate_pipe

Streaming virtual-to-physical (and physical-to-virtual) channel address translator for the paging fabric. It replaces the one-shot, single-address decoder with a valid/ready request stream and a per-request direction bit. Each request carries a tag. The stage network is optionally pipelined. Switch configuration is double-buffered, and the active copy is swapped without corrupting in-flight translations.

## Interface

**Parameters**
- `BITMAP`, 128: number of channels; must be a power of two, ≥4.
- `PIPE`, 0: 0 = one output register; 1 = a register after every stage.
- `TAG_W`, 4: width of the request tag that is carried through.
- Derived: `ADDR_W = $clog2(BITMAP)`, `NODES = BITMAP/2`, `STAGES = ADDR_W`.

**Ports**
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: asynchronous reset, active-low.
- `i_valid`, in, 1: request valid.
- `o_ready`, out, 1: request accepted when `i_valid & o_ready`.
- `i_addr`, in, `ADDR_W`: input channel address.
- `i_dir`, in, 1: 0 = virtual→physical (forward); 1 = physical→virtual (reverse).
- `i_tag`, in, `TAG_W`: request tag.
- `o_valid`, out, 1: result valid.
- `i_ready`, in, 1: downstream accepts the result.
- `o_addr`, out, `ADDR_W`: translated address.
- `o_tag`, out, `TAG_W`: echoed tag.
- `i_cfg_we`, in, 1: load `i_cfg_scb` into the shadow configuration.
- `i_cfg_scb`, in, `[STAGES-1:0][NODES-1:0]`: switch control bits.
- `i_cfg_commit`, in, 1: request a swap of shadow into active.
- `o_cfg_busy`, out, 1: a commit is pending.
- `o_cfg_done`, out, 1: one-cycle pulse when the swap occurs.

## Operation

**Stage rule** (both directions use it)
- Stage `s` operates on address bit `b = ADDR_W-1-s`.
- Node index `n` = the address with bit `b` removed; the upper bits stay above the lower bits.
- If `active[s][n] == 1`, bit `b` is flipped. Otherwise the address passes unchanged.

**Order of stages**
- Forward (`i_dir = 0`) applies stages 0..`STAGES-1` in that order.
- Reverse (`i_dir = 1`) applies stages `STAGES-1`..0.
- Every stage is an involution, so reverse(forward(a)) = a for any configuration.

**Pipeline slots**
- Pipeline slot `k` uses stage `k` when the request is forward, and stage `STAGES-1-k` when it is reverse.
- The direction bit and tag travel with each request.

**Flow control**
- Global advance: `adv = !o_valid | i_ready`.
- All registers, including the output register, load only when `adv` is high.
- A bubble enters whenever no request is accepted.
- `o_ready = adv & !o_cfg_busy`.

**Configuration**
- `i_cfg_we` writes the shadow copy at any time, including while busy.
- `i_cfg_commit` sets `busy`.
- While `busy`, no new requests are accepted.
- Swap condition: busy, and every internal stage register is invalid. With `PIPE = 0` there are no internal registers, so the swap happens the cycle after the commit. The output register is excluded from the condition because its result is already computed.
- At the swap: active ← shadow, `busy` clears, and `o_cfg_done` pulses.
- If `i_cfg_we` and the swap occur in the same cycle, the swap copies the old shadow; the new value stays in the shadow.
- A second `i_cfg_commit` while busy is ignored, and no extra `o_cfg_done` pulse is produced.

## Timing

- **Latency:** `L = 1` (`PIPE = 0`) or `L = STAGES` (`PIPE = 1`) cycles from acceptance to `o_valid`, with no stalls.
- **Throughput:** 1 request per cycle when `i_ready` is held high.
- **Output stability:** `o_addr` and `o_tag` hold while `o_valid & !i_ready`.
- **Reset (asynchronous, active-low), values on assertion:**
  - All valid bits = 0.
  - `o_valid = 0`, `o_addr = 0`, `o_tag = 0`.
  - Active and shadow configuration = 0, i.e. identity translation.
  - `busy = 0`, `o_cfg_done = 0`.
  - `o_ready = 1` from the first edge after deassertion.
- **Reset mid-operation:** in-flight requests and any pending commit are discarded.

## Structure

- **`vtp_pkg`:**
  - `node_idx(addr, bit)` function.
  - Request struct `{addr, dir, tag}`.
  - `ADDR_W`/`NODES` derivation helpers.
- **Sub-module `vtp_xlate_stage`:**
  - One slot's combinational flip that selects stage `s` by `dir`.
  - An optional register stage with `adv` enable.
  - The top level generates `STAGES` instances plus the config and flow-control logic.

## Test plan

All cases use `BITMAP = 8`, so `ADDR_W = 3` and `NODES = 4`.

1. **Identity after reset.** Send addresses 0..7, forward, tags 0..7, `i_ready = 1` → outputs 0..7 in order with matching tags. Latency is 1 with `PIPE = 0` and 3 with `PIPE = 1`.
2. **Single switch.** Load `scb[0][1] = 1`, commit, wait for `o_cfg_done`.
   - 5 forward → 1.
   - 4 forward → 4.
   - 1 forward → 5.
   - 5 reverse → 1.
3. **Round trip.** Load a random configuration. Send all 8 addresses forward, then feed each result back in reverse → the original address, and the forward results form a permutation of 0..7.
4. **Backpressure.** Hold `i_ready = 0` for 5 cycles mid-stream with `PIPE = 1` → `o_addr`/`o_tag` stable, no loss or duplication, order preserved after release.
5. **Commit with traffic in flight.** `PIPE = 1`, 3 requests in flight, commit → `o_ready` drops immediately; the 3 requests complete with the old configuration; `o_cfg_done` arrives 3 cycles later; the next request uses the new configuration.
6. **Reset mid-stream.** Assert `i_rst_n = 0` with 2 requests in flight and a commit pending → `o_valid = 0` and `busy = 0` immediately, and translation returns to identity afterwards.

Source files
------------

// File: rtl/vtp_pkg.sv
// Shared types and helpers for the streaming channel address translator.
// Widths depend on the instance's BITMAP, so the request struct lives in the modules that know them.
package vtp_pkg;

  localparam int MAX_ADDR_W = 16;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  function automatic int addr_w_of(input int bitmap);
    return $clog2(bitmap);
  endfunction

  function automatic int nodes_of(input int bitmap);
    return bitmap / 2;
  endfunction

  // Drop bit b from addr and close the gap: upper bits shift down onto the lower ones.
  function automatic logic [MAX_ADDR_W-1:0] node_idx(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int b);
    logic [MAX_ADDR_W-1:0] low_mask;
    low_mask = (MAX_ADDR_W'(1) << b) - MAX_ADDR_W'(1);
    return ((addr >> (b + 1)) << b) | (addr & low_mask);
  endfunction

endpackage

// File: rtl/vtp_xlate_pipe_if.sv
// Request/result stream and configuration signals of the translator, with host and device views.
interface vtp_xlate_pipe_if #(
  parameter int BITMAP = 128,
  parameter int TAG_W  = 4
);
  localparam int ADDR_W = $clog2(BITMAP);
  localparam int NODES  = BITMAP / 2;
  localparam int STAGES = ADDR_W;

  logic                           i_valid;
  logic                           o_ready;
  logic [ADDR_W-1:0]              i_addr;
  logic                           i_dir;
  logic [TAG_W-1:0]               i_tag;
  logic                           o_valid;
  logic                           i_ready;
  logic [ADDR_W-1:0]              o_addr;
  logic [TAG_W-1:0]               o_tag;
  logic                           i_cfg_we;
  logic [STAGES-1:0][NODES-1:0]   i_cfg_scb;
  logic                           i_cfg_commit;
  logic                           o_cfg_busy;
  logic                           o_cfg_done;

  modport slave (
    input  i_valid, i_addr, i_dir, i_tag, i_ready, i_cfg_we, i_cfg_scb, i_cfg_commit,
    output o_ready, o_valid, o_addr, o_tag, o_cfg_busy, o_cfg_done
  );

  modport master (
    output i_valid, i_addr, i_dir, i_tag, i_ready, i_cfg_we, i_cfg_scb, i_cfg_commit,
    input  o_ready, o_valid, o_addr, o_tag, o_cfg_busy, o_cfg_done
  );

endinterface

// File: rtl/vtp_xlate_stage.sv
// One pipeline slot: applies the forward or reverse stage chosen by the request direction,
// optionally followed by a register that loads only when the pipe advances.
module vtp_xlate_stage
  import vtp_pkg::*;
#(
  parameter int BITMAP = 128,
  parameter int TAG_W  = 4,
  parameter int SLOT   = 0,
  parameter int REG    = 0,
  localparam int ADDR_W = $clog2(BITMAP),
  localparam int NODES  = BITMAP / 2,
  localparam int STAGES = ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adv,
  input  logic [STAGES-1:0][NODES-1:0] cfg,
  input  logic                         in_valid,
  input  logic [ADDR_W-1:0]            in_addr,
  input  dir_e                         in_dir,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_addr,
  output dir_e                         out_dir,
  output logic [TAG_W-1:0]             out_tag
);

  localparam int NIDX_W = ADDR_W - 1;
  localparam int S_FWD  = SLOT;
  localparam int S_REV  = STAGES - 1 - SLOT;
  localparam int B_FWD  = ADDR_W - 1 - S_FWD;
  localparam int B_REV  = ADDR_W - 1 - S_REV;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    dir_e              dir;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t              cur;
  req_t              nxt;
  logic [NIDX_W-1:0] node_fwd;
  logic [NIDX_W-1:0] node_rev;

  assign cur      = '{addr: in_addr, dir: in_dir, tag: in_tag};
  assign node_fwd = NIDX_W'(node_idx(MAX_ADDR_W'(in_addr), B_FWD));
  assign node_rev = NIDX_W'(node_idx(MAX_ADDR_W'(in_addr), B_REV));

  always_comb begin
    nxt = cur;
    if (cur.dir == DIR_FWD) begin
      if (cfg[S_FWD][node_fwd]) nxt.addr[B_FWD] = ~cur.addr[B_FWD];
    end else begin
      if (cfg[S_REV][node_rev]) nxt.addr[B_REV] = ~cur.addr[B_REV];
    end
  end

  generate
    if (REG != 0) begin : g_reg
      req_t req_q;
      logic valid_q;

      // Data is only captured for real requests so a stalled or idle output keeps its value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          req_q   <= '0;
        end else if (adv) begin
          valid_q <= in_valid;
          if (in_valid) req_q <= nxt;
        end
      end

      assign out_valid = valid_q;
      assign out_addr  = req_q.addr;
      assign out_dir   = req_q.dir;
      assign out_tag   = req_q.tag;
    end else begin : g_comb
      logic unused_regs;
      assign unused_regs = &{1'b0, clk, rst_n, adv};
      assign out_valid   = in_valid;
      assign out_addr    = nxt.addr;
      assign out_dir     = nxt.dir;
      assign out_tag     = nxt.tag;
    end
  endgenerate

endmodule

// File: rtl/vtp_xlate_pipe.sv
// Streaming channel address translator: a chain of per-bit switch stages with a tagged
// valid/ready stream and a double-buffered switch configuration swapped between requests.
module vtp_xlate_pipe
  import vtp_pkg::*;
#(
  parameter int BITMAP = 128,
  parameter int PIPE   = 0,
  parameter int TAG_W  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  vtp_xlate_pipe_if.slave bus
);

  localparam int ADDR_W = addr_w_of(BITMAP);
  localparam int NODES  = nodes_of(BITMAP);
  localparam int STAGES = ADDR_W;

  logic [STAGES-1:0][NODES-1:0] active_cfg;
  logic [STAGES-1:0][NODES-1:0] shadow_cfg;
  cfg_state_e                   state;
  cfg_state_e                   state_nxt;
  logic                         swap;
  logic                         done_q;
  logic                         busy;
  logic                         adv;
  logic                         ready;
  logic                         internal_busy;

  logic [STAGES:0]              s_valid;
  logic [ADDR_W-1:0]            s_addr [STAGES+1];
  dir_e                         s_dir  [STAGES+1];
  logic [TAG_W-1:0]             s_tag  [STAGES+1];
  logic                         unused_out_dir;

  assign busy       = (state == CFG_PENDING);
  assign adv        = !bus.o_valid | bus.i_ready;
  assign ready      = adv & !busy;
  assign bus.o_ready = ready;

  assign s_valid[0] = bus.i_valid & ready;
  assign s_addr[0]  = bus.i_addr;
  assign s_dir[0]   = dir_e'(bus.i_dir);
  assign s_tag[0]   = bus.i_tag;

  // The last slot is always registered: it is the output register in both pipeline modes.
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
      vtp_xlate_stage #(
        .BITMAP (BITMAP),
        .TAG_W  (TAG_W),
        .SLOT   (k),
        .REG    (((k == STAGES - 1) || (PIPE != 0)) ? 1 : 0)
      ) u_stage (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .adv       (adv),
        .cfg       (active_cfg),
        .in_valid  (s_valid[k]),
        .in_addr   (s_addr[k]),
        .in_dir    (s_dir[k]),
        .in_tag    (s_tag[k]),
        .out_valid (s_valid[k+1]),
        .out_addr  (s_addr[k+1]),
        .out_dir   (s_dir[k+1]),
        .out_tag   (s_tag[k+1])
      );
    end

    if (PIPE != 0) begin : g_int_busy
      assign internal_busy = |s_valid[STAGES-1:1];
    end else begin : g_no_int
      assign internal_busy = 1'b0;
    end
  endgenerate

  assign bus.o_valid = s_valid[STAGES];
  assign bus.o_addr  = s_addr[STAGES];
  assign bus.o_tag   = s_tag[STAGES];
  assign unused_out_dir = logic'(s_dir[STAGES]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= CFG_IDLE;
    else          state <= state_nxt;
  end

  // A pending commit waits until no request sits inside the stage registers; the output
  // register already holds a finished result and does not hold the swap back.
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    case (state)
      CFG_IDLE:    if (bus.i_cfg_commit) state_nxt = CFG_PENDING;
      CFG_PENDING: if (!internal_busy) begin
        swap      = 1'b1;
        state_nxt = CFG_IDLE;
      end
      default:     state_nxt = CFG_IDLE;
    endcase
  end

  // Swap reads the shadow before this cycle's write lands, so a coincident write stays shadowed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_cfg <= '0;
      active_cfg <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= swap;
      if (bus.i_cfg_we) shadow_cfg <= bus.i_cfg_scb;
      if (swap)         active_cfg <= shadow_cfg;
    end
  end

  assign bus.o_cfg_busy = busy;
  assign bus.o_cfg_done = done_q;

endmodule
